// File: rtl/cnt_req_pkg.sv
// Shared types and constants for the counter request controller.
package cnt_req_pkg;

  // Width of the downstream up/down counter value.
  localparam int unsigned CNT_W = 4;

  // Controller FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StIssueUp,
    StIssueDown,
    StSettle
  } state_e;

endpackage

// File: rtl/pend_cnt.sv
// Pending-credit counter. inc and dec in the same cycle cancel.
// Increments are ignored when full and decrements when empty, so the count never wraps.
module pend_cnt #(
  parameter int unsigned PEND_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic nonzero
);

  logic [PEND_W-1:0] count_q, count_d;

  assign full    = &count_q;
  assign nonzero = |count_q;

  // Next credit count.
  always_comb begin
    count_d = count_q;
    if (inc && !dec && !full) begin
      count_d = count_q + PEND_W'(1);
    end else if (dec && !inc && nonzero) begin
      count_d = count_q - PEND_W'(1);
    end
  end

  // Credit register, synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cnt_req_ctrl.sv
// Upstream controller for the 4-bit up/down counter stage.
// Queues producer requests as credits and issues one-cycle step enables,
// dropping steps that would push the counter past MAX_CNT / MIN_CNT.
// Build option: define CNT_REQ_SAT_STICKY_EN to make sat_drop a sticky flag
// that holds until reset; otherwise it pulses once per dropped request.
module cnt_req_ctrl
  import cnt_req_pkg::*;
#(
  parameter int unsigned PEND_W  = 3,
  parameter int unsigned MAX_CNT = 15,
  parameter int unsigned MIN_CNT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_req,
  input  logic             down_req,
  output logic             req_ready,
  input  logic [CNT_W-1:0] cnt_val,
  output logic             up_cnt_en,
  output logic             down_cnt_en,
  output logic             busy,
  output logic             sat_drop
);

  localparam logic [CNT_W-1:0] MaxVal = CNT_W'(MAX_CNT);
  localparam logic [CNT_W-1:0] MinVal = CNT_W'(MIN_CNT);

  state_e state_q, state_d;
  logic   sat_q;
  logic   up_inc, up_dec, up_full, up_nz;
  logic   dn_inc, dn_dec, dn_full, dn_nz;
  logic   drop;

  assign req_ready = !up_full && !dn_full;

  // Simultaneous up and down requests cancel, so neither credit is taken.
  assign up_inc = req_ready && up_req && !down_req;
  assign dn_inc = req_ready && down_req && !up_req;

  pend_cnt #(
    .PEND_W (PEND_W)
  ) u_up_pend (
    .clk     (clk),
    .rst     (rst),
    .inc     (up_inc),
    .dec     (up_dec),
    .full    (up_full),
    .nonzero (up_nz)
  );

  pend_cnt #(
    .PEND_W (PEND_W)
  ) u_down_pend (
    .clk     (clk),
    .rst     (rst),
    .inc     (dn_inc),
    .dec     (dn_dec),
    .full    (dn_full),
    .nonzero (dn_nz)
  );

  // IDLE decision in priority order; issue states consume one credit each.
  always_comb begin
    state_d = state_q;
    up_dec  = 1'b0;
    dn_dec  = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (up_nz && dn_nz) begin
          // Opposing credits annihilate without touching the counter.
          up_dec = 1'b1;
          dn_dec = 1'b1;
        end else if (up_nz && (cnt_val == MaxVal)) begin
          up_dec = 1'b1;
          drop   = 1'b1;
        end else if (up_nz) begin
          state_d = StIssueUp;
        end else if (dn_nz && (cnt_val == MinVal)) begin
          dn_dec = 1'b1;
          drop   = 1'b1;
        end else if (dn_nz) begin
          state_d = StIssueDown;
        end
      end
      StIssueUp: begin
        up_dec  = 1'b1;
        state_d = StSettle;
      end
      StIssueDown: begin
        dn_dec  = 1'b1;
        state_d = StSettle;
      end
      // Gives the counter one edge so cnt_val is current at the next decision.
      StSettle: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state and registered saturation indication.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
`ifdef CNT_REQ_SAT_STICKY_EN
      sat_q   <= sat_q | drop;
`else
      sat_q   <= drop;
`endif
    end
  end

  // Moore enables decoded from the state register; mutually exclusive by construction.
  assign up_cnt_en   = (state_q == StIssueUp);
  assign down_cnt_en = (state_q == StIssueDown);
  assign sat_drop    = sat_q;
  assign busy        = (state_q != StIdle) || up_nz || dn_nz;

endmodule

// File: tb/tb_cnt_req_ctrl.sv
// Directed bench for cnt_req_ctrl with hand-computed expectations.
module tb_cnt_req_ctrl;

`ifdef CNT_REQ_SAT_STICKY_EN
  localparam logic StickyExp = 1'b1;
`else
  localparam logic StickyExp = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, up_req, down_req;
  logic       req_ready, up_cnt_en, down_cnt_en, busy, sat_drop;
  logic [3:0] cnt_val;
  bit         track;

  int total, bad, cyc_n, up_n, dn_n, acc_n;
  int up_at[$];

  always #5 clk = ~clk;

  cnt_req_ctrl #(
    .PEND_W  (3),
    .MAX_CNT (15),
    .MIN_CNT (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .up_req      (up_req),
    .down_req    (down_req),
    .req_ready   (req_ready),
    .cnt_val     (cnt_val),
    .up_cnt_en   (up_cnt_en),
    .down_cnt_en (down_cnt_en),
    .busy        (busy),
    .sat_drop    (sat_drop)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: sample this cycle's outputs, pass the edge, settle 1ns, update the counter model.
  task automatic cyc();
    logic ue, de, acc;
    ue  = up_cnt_en;
    de  = down_cnt_en;
    acc = req_ready && up_req && !down_req;
    @(posedge clk);
    #1;
    if (ue) begin
      up_n++;
      up_at.push_back(cyc_n);
    end
    if (de) dn_n++;
    if (acc) acc_n++;
    if (track) cnt_val = cnt_val + 4'(ue) - 4'(de);
    cyc_n++;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic clr();
    up_n  = 0;
    dn_n  = 0;
    acc_n = 0;
    up_at.delete();
  endtask

  initial begin
    total = 0; bad = 0; cyc_n = 0;
    rst = 1'b0; up_req = 1'b0; down_req = 1'b0; cnt_val = 4'd3; track = 1'b0;
    clr();
    run(2);
    rst = 1'b1;

    // Reset state
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_up_en", up_cnt_en, 0);
    check_eq("rst_dn_en", down_cnt_en, 0);
    check_eq("rst_sat", sat_drop, 0);

    // Single up request: enable two cycles after accept, busy clears two cycles later
    clr();
    up_req = 1'b1; cyc(); up_req = 1'b0;
    check_eq("t1_c1_up_en", up_cnt_en, 0);
    check_eq("t1_c1_busy", busy, 1);
    cyc();
    check_eq("t1_c2_up_en", up_cnt_en, 1);
    check_eq("t1_c2_dn_en", down_cnt_en, 0);
    cyc();
    check_eq("t1_c3_up_en", up_cnt_en, 0);
    check_eq("t1_c3_busy", busy, 1);
    cyc();
    check_eq("t1_c4_busy", busy, 0);
    check_eq("t1_pulses", up_n, 1);

    // Three back-to-back ups with the counter tracked from 0: pulses every third cycle
    clr();
    cnt_val = 4'd0; track = 1'b1;
    up_req = 1'b1; run(3); up_req = 1'b0;
    run(10);
    check_eq("t2_pulses", up_n, 3);
    if (up_at.size() == 3) begin
      check_eq("t2_gap0", up_at[1] - up_at[0], 3);
      check_eq("t2_gap1", up_at[2] - up_at[1], 3);
    end
    check_eq("t2_cnt", cnt_val, 3);
    check_eq("t2_busy", busy, 0);
    track = 1'b0;

    // Simultaneous up and down cancel at the input
    clr();
    cnt_val = 4'd5;
    up_req = 1'b1; down_req = 1'b1; cyc(); up_req = 1'b0; down_req = 1'b0;
    check_eq("t3a_busy", busy, 0);
    run(5);
    check_eq("t3a_up", up_n, 0);
    check_eq("t3a_dn", dn_n, 0);

    // up pending 2, down pending 1: one cancel cycle then one up pulse
    clr();
    up_req = 1'b1; cyc(); cyc();
    check_eq("t3b_c2_up_en", up_cnt_en, 1);
    cyc();
    up_req = 1'b0; down_req = 1'b1; cyc(); down_req = 1'b0;
    check_eq("t3b_c4_up_en", up_cnt_en, 0);
    check_eq("t3b_c4_dn_en", down_cnt_en, 0);
    check_eq("t3b_c4_busy", busy, 1);
    cyc();
    check_eq("t3b_c5_up_en", up_cnt_en, 0);
    cyc();
    check_eq("t3b_c6_up_en", up_cnt_en, 1);
    run(2);
    check_eq("t3b_busy", busy, 0);
    check_eq("t3b_up", up_n, 2);
    check_eq("t3b_dn", dn_n, 0);

    // Saturation drops at both limits
    clr();
    cnt_val = 4'd15;
    up_req = 1'b1; cyc(); up_req = 1'b0;
    check_eq("t4_c1_sat", sat_drop, 0);
    cyc();
    check_eq("t4_c2_sat", sat_drop, 1);
    check_eq("t4_c2_busy", busy, 0);
    cyc();
    check_eq("t4_c3_sat", sat_drop, StickyExp);
    run(3);
    check_eq("t4_up", up_n, 0);
    rst = 1'b0; cyc(); rst = 1'b1;
    cnt_val = 4'd0;
    down_req = 1'b1; cyc(); down_req = 1'b0;
    cyc();
    check_eq("t4_dn_sat", sat_drop, 1);
    cyc();
    check_eq("t4_dn_sat_after", sat_drop, StickyExp);
    check_eq("t4_dn", dn_n, 0);
    rst = 1'b0; cyc(); rst = 1'b1;
    check_eq("t4_sat_rst", sat_drop, 0);

    // Held up request: credits fill to 7, ready drops then recovers after an issue
    clr();
    cnt_val = 4'd5;
    up_req = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i == 10) check_eq("t5_ready_full", req_ready, 0);
      if (i == 12) check_eq("t5_ready_back", req_ready, 1);
      cyc();
    end
    up_req = 1'b0;
    check_eq("t5_accepts", acc_n, 11);
    run(30);
    check_eq("t5_pulses", up_n, 11);
    check_eq("t5_busy", busy, 0);

    // Reset while issuing with four credits pending
    clr();
    up_req = 1'b1; run(5);
    check_eq("t6_in_issue", up_cnt_en, 1);
    up_req = 1'b0; rst = 1'b0; cyc();
    check_eq("t6_up_en", up_cnt_en, 0);
    check_eq("t6_dn_en", down_cnt_en, 0);
    check_eq("t6_ready", req_ready, 1);
    check_eq("t6_busy", busy, 0);
    rst = 1'b1;
    run(6);
    check_eq("t6_up", up_n, 2);
    check_eq("t6_dn", dn_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
